// File: rtl/instr_sequencer.sv
// Fetch/execute control FSM for the datapath: sequences T0-T2 fetch and T3-T6 execute for
// register-register ALU, multiply/divide and unary instructions, with a memory-ready stall in T1.
module instr_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             run_i,
    input  logic [31:0]      ir_i,
    input  logic             mem_rdy_i,
    output logic             pc_out_o,
    output logic             pc_increment_o,
    output logic             mar_in_o,
    output logic             zlow_in_o,
    output logic             zhigh_in_o,
    output logic             zlow_out_o,
    output logic             zhigh_out_o,
    output logic             pc_in_o,
    output logic             read_o,
    output logic             mdr_in_o,
    output logic             mdr_out_o,
    output logic             ir_in_o,
    output logic             y_in_o,
    output logic             hi_in_o,
    output logic             lo_in_o,
    output logic [15:0]      rin_o,
    output logic [15:0]      rout_o,
    output logic [4:0]       op_code_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       cls_3reg, cls_md, cls_un, cls_hlt;

    assign opc = ir_i[31:27];
    assign ra  = ir_i[26:23];
    assign rb  = ir_i[22:19];
    assign rc  = ir_i[18:15];

    assign cls_3reg = (opc <= 5'd12);
    assign cls_md   = (opc == 5'd15) || (opc == 5'd16);
    assign cls_un   = (opc == 5'd17) || (opc == 5'd18);
    assign cls_hlt  = (opc == 5'd27);

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        cnt_d          = cnt_q;
        pc_out_o       = 1'b0;
        pc_increment_o = 1'b0;
        mar_in_o       = 1'b0;
        zlow_in_o      = 1'b0;
        zhigh_in_o     = 1'b0;
        zlow_out_o     = 1'b0;
        zhigh_out_o    = 1'b0;
        pc_in_o        = 1'b0;
        read_o         = 1'b0;
        mdr_in_o       = 1'b0;
        mdr_out_o      = 1'b0;
        ir_in_o        = 1'b0;
        y_in_o         = 1'b0;
        hi_in_o        = 1'b0;
        lo_in_o        = 1'b0;
        rin_o          = '0;
        rout_o         = '0;
        op_code_o      = '0;
        done_o         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_i) state_d = StT0;
            end
            StT0: begin
                pc_out_o       = 1'b1;
                pc_increment_o = 1'b1;
                mar_in_o       = 1'b1;
                zlow_in_o      = 1'b1;
                zhigh_in_o     = 1'b1;
                state_d        = StT1;
            end
            StT1: begin
                zlow_out_o = 1'b1;
                read_o     = 1'b1;
                mdr_in_o   = 1'b1;
                // PC is loaded only on the exit cycle so a stalled fetch advances it once
                if (mem_rdy_i) begin
                    pc_in_o = 1'b1;
                    state_d = StT2;
                end
            end
            StT2: begin
                mdr_out_o = 1'b1;
                ir_in_o   = 1'b1;
                state_d   = StT3;
            end
            StT3: begin
                if (cls_hlt) begin
                    state_d = StHalt;
                end else if (cls_3reg) begin
                    rout_o  = onehot(rb);
                    y_in_o  = 1'b1;
                    state_d = StT4;
                end else if (cls_md) begin
                    rout_o  = onehot(ra);
                    y_in_o  = 1'b1;
                    state_d = StT4;
                end else if (cls_un) begin
                    state_d = StT4;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end
            end
            StT4: begin
                op_code_o  = opc;
                zlow_in_o  = 1'b1;
                zhigh_in_o = 1'b1;
                rout_o     = cls_3reg ? onehot(rc) : onehot(rb);
                state_d    = StT5;
            end
            StT5: begin
                zlow_out_o = 1'b1;
                if (cls_md) begin
                    lo_in_o = 1'b1;
                    state_d = StT6;
                end else begin
                    rin_o   = onehot(ra);
                    done_o  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = run_i ? StT0 : StIdle;
                end
            end
            StT6: begin
                zhigh_out_o = 1'b1;
                hi_in_o     = 1'b1;
                done_o      = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                state_d     = run_i ? StT0 : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o        = (state_q != StIdle) && (state_q != StHalt);
    assign halted_o      = (state_q == StHalt);
    assign illegal_o     = illegal_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer: per-instruction expectations are queued at
// issue time and a monitor compares the observed control trace at every done pulse.
module tb_instr_sequencer;

    localparam int unsigned CntW  = 16;
    localparam int          NRand = 40;

    logic            clk, rst_n, run_i, mem_rdy_i;
    logic [31:0]     ir_i;
    logic            pc_out_o, pc_increment_o, mar_in_o, zlow_in_o, zhigh_in_o;
    logic            zlow_out_o, zhigh_out_o, pc_in_o, read_o, mdr_in_o, mdr_out_o;
    logic            ir_in_o, y_in_o, hi_in_o, lo_in_o;
    logic [15:0]     rin_o, rout_o;
    logic [4:0]      op_code_o;
    logic            busy_o, done_o, halted_o, illegal_o;
    logic [CntW-1:0] instr_count_o;

    instr_sequencer #(.CNT_W(CntW)) dut (
        .clk_i         (clk),
        .clr_ni        (rst_n),
        .run_i         (run_i),
        .ir_i          (ir_i),
        .mem_rdy_i     (mem_rdy_i),
        .pc_out_o      (pc_out_o),
        .pc_increment_o(pc_increment_o),
        .mar_in_o      (mar_in_o),
        .zlow_in_o     (zlow_in_o),
        .zhigh_in_o    (zhigh_in_o),
        .zlow_out_o    (zlow_out_o),
        .zhigh_out_o   (zhigh_out_o),
        .pc_in_o       (pc_in_o),
        .read_o        (read_o),
        .mdr_in_o      (mdr_in_o),
        .mdr_out_o     (mdr_out_o),
        .ir_in_o       (ir_in_o),
        .y_in_o        (y_in_o),
        .hi_in_o       (hi_in_o),
        .lo_in_o       (lo_in_o),
        .rin_o         (rin_o),
        .rout_o        (rout_o),
        .op_code_o     (op_code_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .halted_o      (halted_o),
        .illegal_o     (illegal_o),
        .instr_count_o (instr_count_o)
    );

    logic [71:0] all_outs;
    assign all_outs = {pc_out_o, pc_increment_o, mar_in_o, zlow_in_o, zhigh_in_o, zlow_out_o,
                       zhigh_out_o, pc_in_o, read_o, mdr_in_o, mdr_out_o, ir_in_o, y_in_o,
                       hi_in_o, lo_in_o, rin_o, rout_o, op_code_o, busy_o, done_o, halted_o,
                       illegal_o, instr_count_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        int          stall;
    } fetch_t;

    typedef struct {
        int              cycles;
        int              reads;
        int              lo;
        int              hi;
        logic [31:0]     rseq;
        logic [15:0]     rin;
        logic [4:0]      op;
        logic [CntW-1:0] cnt;
    } exp_t;

    fetch_t fq[$];
    exp_t   eq[$];
    int     tests = 0;
    int     fails = 0;
    int     n_issued = 0;
    int     n_target = 0;
    int     fetched = 0;
    bit     rand_phase = 0;
    bit     run_cmd = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] push_idx(input logic [31:0] seq, input int idx);
        return {seq[26:0], 5'(idx + 1)};
    endfunction

    // Reference: instruction class decides length, operand order, destination and HI/LO writes
    function automatic exp_t model(input logic [31:0] ir, input int stall, input int idx);
        exp_t e;
        int   opc = int'(ir[31:27]);
        int   ra  = int'(ir[26:23]);
        int   rb  = int'(ir[22:19]);
        int   rc  = int'(ir[18:15]);
        bit   md  = (opc == 15) || (opc == 16);
        bit   un  = (opc == 17) || (opc == 18);
        e.cycles = 6 + stall + (md ? 1 : 0);
        e.reads  = stall + 1;
        e.lo     = md ? 1 : 0;
        e.hi     = md ? 1 : 0;
        e.op     = 5'(opc);
        e.rseq   = '0;
        if (md) e.rseq = push_idx(push_idx(e.rseq, ra), rb);
        else if (un) e.rseq = push_idx(e.rseq, rb);
        else e.rseq = push_idx(push_idx(e.rseq, rb), rc);
        e.rin = md ? 16'h0 : 16'(1 << ra);
        e.cnt = CntW'(idx + 1);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k = int'($urandom_range(0, 16));
        int opc;
        if (k <= 12) opc = k;
        else if (k <= 14) opc = 15 + (k - 13);
        else opc = 17 + (k - 15);
        return {5'(opc), 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    task automatic fetch_only(input logic [31:0] ir, input int stall);
        fetch_t f;
        f.ir    = ir;
        f.stall = stall;
        fq.push_back(f);
    endtask

    task automatic issue(input logic [31:0] ir, input int stall);
        fetch_only(ir, stall);
        eq.push_back(model(ir, stall, n_issued));
        n_issued++;
    endtask

    // Memory responder: holds mem_rdy low for the planned number of T1 cycles
    initial begin
        int t1n;
        int s;
        t1n = 0;
        mem_rdy_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (read_o) begin
                s = (fq.size() > 0) ? fq[0].stall : 0;
                mem_rdy_i = (t1n >= s);
                t1n++;
            end else begin
                t1n = 0;
                mem_rdy_i = 1'($urandom);
            end
        end
    end

    // Datapath IR load and run control
    initial begin
        fetch_t f;
        ir_i  = '0;
        run_i = 1'b0;
        forever begin
            @(negedge clk);
            if (pc_out_o) fetched++;
            if (ir_in_o) begin
                if (fq.size() > 0) begin
                    f = fq.pop_front();
                    ir_i = f.ir;
                end else begin
                    ir_i = 32'hD800_0000;
                end
            end
            if (rand_phase) run_i = (fetched < n_target) && ($urandom_range(0, 4) != 0);
            else run_i = run_cmd;
        end
    end

    // Monitor: gathers one instruction's trace from T0 and scores it on done
    initial begin
        bit              obs, chk_next, exp_run, inv_ok;
        int              cyc, reads, pcins, lo, hi;
        logic [31:0]     rseq;
        logic [15:0]     rin;
        logic [4:0]      op;
        logic [CntW-1:0] exp_cnt;
        exp_t            e;
        obs = 0;
        chk_next = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                obs = 0;
                chk_next = 0;
            end else begin
                if (chk_next) begin
                    check("restart_after_done", pc_out_o, exp_run);
                    check("instr_count", instr_count_o, exp_cnt);
                    chk_next = 0;
                end
                if (pc_out_o) begin
                    obs = 1; cyc = 0; reads = 0; pcins = 0; lo = 0; hi = 0;
                    rseq = '0; rin = '0; op = 5'h1F; inv_ok = 1;
                end
                if (obs) begin
                    cyc++;
                    if (read_o) reads++;
                    if (pc_in_o) pcins++;
                    if (lo_in_o) lo++;
                    if (hi_in_o) hi++;
                    if (rout_o != 0) begin
                        for (int i = 0; i < 16; i++) if (rout_o[i]) rseq = push_idx(rseq, i);
                    end
                    rin = rin | rin_o;
                    if (zlow_in_o && !pc_out_o) op = op_code_o;
                    if ($countones(rout_o) > 1) inv_ok = 0;
                    if ((pc_out_o || zlow_out_o || zhigh_out_o || mdr_out_o) && rout_o != 0)
                        inv_ok = 0;
                    if (!(zlow_in_o && !pc_out_o) && op_code_o != 0) inv_ok = 0;
                    if (!busy_o || halted_o) inv_ok = 0;
                    if (done_o) begin
                        check("exp_queue_nonempty", eq.size() > 0, 1);
                        if (eq.size() > 0) begin
                            e = eq.pop_front();
                            check("cycles", cyc, e.cycles);
                            check("read_cycles", reads, e.reads);
                            check("pc_in_pulses", pcins, 1);
                            check("rout_sequence", rseq, e.rseq);
                            check("rin", rin, e.rin);
                            check("op_code", op, e.op);
                            check("lo_in", lo, e.lo);
                            check("hi_in", hi, e.hi);
                            check("invariants", inv_ok, 1);
                            exp_cnt = e.cnt;
                        end
                        exp_run  = run_i;
                        chk_next = 1;
                        obs      = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #2 check("idle_after_reset", all_outs, 0);

        issue(32'h521B_8000, 0);
        issue(32'h7988_0000, 0);
        issue(32'h0091_8000, 3);
        repeat (3) issue(32'h8A90_0000, 0);
        for (int i = 0; i < NRand; i++)
            issue(rand_instr(), ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3)));
        n_target   = n_issued;
        fetched    = 0;
        rand_phase = 1;
        for (int c = 0; c < 5000 && !(eq.size() == 0 && fetched == n_target); c++)
            @(negedge clk);
        check("stream_complete", eq.size(), 0);
        rand_phase = 0;
        run_cmd    = 0;
        repeat (3) @(negedge clk);
        #2;
        check("idle_after_stream", busy_o, 0);
        check("count_after_stream", instr_count_o, n_target);

        // Reset in the middle of T4 must abort with every output low
        fetch_only(32'h0091_8000, 0);
        run_cmd = 1;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = zlow_in_o && !pc_out_o;
        end
        check("reached_t4", seen, 1);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", all_outs, 0);
        run_cmd = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 check("idle_after_abort", all_outs, 0);

        fetch_only(32'hD800_0000, 1);
        run_cmd = 1;
        for (int c = 0; c < 50 && !halted_o; c++) @(negedge clk);
        #2;
        check("hlt_halted", halted_o, 1);
        check("hlt_busy", busy_o, 0);
        check("hlt_illegal", illegal_o, 0);
        check("hlt_count", instr_count_o, 0);
        repeat (5) @(negedge clk);
        #2;
        check("hlt_ignores_run", {halted_o, pc_out_o, busy_o}, 3'b100);
        rst_n = 1'b0;
        run_cmd = 0;
        #1 check("hlt_reset", all_outs, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        fetch_only(32'hF800_0000, 2);
        run_cmd = 1;
        for (int c = 0; c < 50 && !halted_o; c++) @(negedge clk);
        #2;
        check("illegal_flag", illegal_o, 1);
        check("illegal_halted", halted_o, 1);
        check("illegal_count", instr_count_o, 0);
        repeat (3) @(negedge clk);
        #2 check("illegal_sticky", illegal_o, 1);
        rst_n = 1'b0;
        run_cmd = 0;
        #1 check("illegal_cleared", all_outs, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
